// File: rtl/instr_issue_queue_pkg.sv
// Shared RV32I and Tomasulo type definitions.
// The issue queue stores one control word plus its RVFI record per entry.
package rv32i_types;
  typedef struct packed {
    logic [31:0] order;
    logic [31:0] insn;
    logic [31:0] pc_rdata;
  } rvfi_word;
endpackage

package tomasula_types;
  import rv32i_types::*;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } ctl_word;

  typedef struct packed {
    ctl_word  cw;
    rvfi_word rvfi;
  } iq_entry_t;
endpackage

// File: rtl/instr_issue_queue_storage.sv
// Entry array for the issue queue.
// Has one write port and one asynchronous read port; contents are not reset.
module iq_storage
  import tomasula_types::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  iq_entry_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output iq_entry_t        rdata
);

  iq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issue_queue.sv
// In-order issue queue between the IR and dispatch.
// Pointers carry an extra wrap bit so that full and empty can be told apart.
module instr_issue_queue
  import tomasula_types::*;
  import rv32i_types::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  ctl_word        control_word,
  input  logic           ld_iq,
  input  rvfi_word       rvfi,
  output logic           issue_q_full_n,
  output logic           ack_o,
  output logic           dq_valid_o,
  input  logic           dq_ready_i,
  output ctl_word        dq_control_word,
  output rvfi_word       dq_rvfi,
  output logic [PTR_W:0] count_o
);

  localparam logic [PTR_W:0] ONE = 1;

  logic [PTR_W:0] head_ptr;
  logic [PTR_W:0] tail_ptr;
  logic           full;
  logic           empty;
  logic           enq;
  logic           deq;
  iq_entry_t      wr_entry;
  iq_entry_t      rd_entry;

  assign empty = (tail_ptr == head_ptr);
  assign full  = (tail_ptr[PTR_W-1:0] == head_ptr[PTR_W-1:0])
              && (tail_ptr[PTR_W] != head_ptr[PTR_W]);

  assign enq = ld_iq && !full && !flush;
  assign deq = !empty && dq_ready_i && !flush;

  assign issue_q_full_n = !full;
  assign dq_valid_o     = !empty;
  assign count_o        = tail_ptr - head_ptr;

  assign wr_entry.cw   = control_word;
  assign wr_entry.rvfi = rvfi;

  iq_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (enq),
    .waddr (tail_ptr[PTR_W-1:0]),
    .wdata (wr_entry),
    .raddr (head_ptr[PTR_W-1:0]),
    .rdata (rd_entry)
  );

  assign dq_control_word = rd_entry.cw;
  assign dq_rvfi         = rd_entry.rvfi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      ack_o    <= 1'b0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      ack_o    <= 1'b0;
    end else begin
      if (enq) tail_ptr <= tail_ptr + ONE;
      if (deq) head_ptr <= head_ptr + ONE;
      ack_o <= enq;
    end
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: vector table, random streams, flush and reset.
// Outputs are sampled on the falling edge against a queue-based model.
module tb_instr_issue_queue;
  import tomasula_types::*;
  import rv32i_types::*;

  localparam int DEPTH = 8;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     flush = 1'b0;
  ctl_word  control_word = '0;
  logic     ld_iq = 1'b0;
  rvfi_word rvfi = '0;
  logic     issue_q_full_n;
  logic     ack_o;
  logic     dq_valid_o;
  logic     dq_ready_i = 1'b0;
  ctl_word  dq_control_word;
  rvfi_word dq_rvfi;
  logic [3:0] count_o;

  instr_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .control_word    (control_word),
    .ld_iq           (ld_iq),
    .rvfi            (rvfi),
    .issue_q_full_n  (issue_q_full_n),
    .ack_o           (ack_o),
    .dq_valid_o      (dq_valid_o),
    .dq_ready_i      (dq_ready_i),
    .dq_control_word (dq_control_word),
    .dq_rvfi         (dq_rvfi),
    .count_o         (count_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  iq_entry_t q[$];
  bit        ack_m = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("count", 128'(count_o), 128'(q.size()));
    chk("valid", 128'(dq_valid_o), 128'(q.size() > 0));
    chk("full_n", 128'(issue_q_full_n), 128'(q.size() < DEPTH));
    chk("ack", 128'(ack_o), 128'(ack_m));
    if (q.size() > 0) begin
      chk("head_cw", 128'(dq_control_word), 128'(q[0].cw));
      chk("head_rvfi", 128'(dq_rvfi), 128'(q[0].rvfi));
    end
  endtask

  task automatic rand_data(output ctl_word cw, output rvfi_word rv);
    logic [63:0] c;
    logic [95:0] r;
    c = {$urandom(), $urandom()};
    r = {$urandom(), $urandom(), $urandom()};
    cw = c;
    rv = r;
  endtask

  // One clock: drive after a falling edge, update model at the rising edge,
  // then compare at the next falling edge.
  task automatic cycle(input bit ld, input ctl_word cw, input rvfi_word rv,
                       input bit rdy, input bit fl, output bit accepted);
    bit enq, deq;
    iq_entry_t e;
    ld_iq        = ld;
    control_word = cw;
    rvfi         = rv;
    dq_ready_i   = rdy;
    flush        = fl;
    enq = ld && (q.size() < DEPTH) && !fl;
    deq = (q.size() > 0) && rdy && !fl;
    e.cw   = cw;
    e.rvfi = rv;
    @(posedge clk);
    if (fl) begin
      q.delete();
      ack_m = 0;
    end else begin
      if (deq) void'(q.pop_front());
      if (enq) q.push_back(e);
      ack_m = enq;
    end
    accepted = enq;
    @(negedge clk);
    chk_model();
  endtask

  typedef struct {
    bit ld;
    bit rdy;
    bit fl;
    int cnt;
    bit ack;
    bit fn;
    bit v;
  } vec_t;

  vec_t tbl[16];

  initial begin
    ctl_word  cw;
    rvfi_word rv;
    bit       acc;
    int       sent;
    int       budget;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{1, 0, 0, i + 1, 1, (i != 7), 1};
    tbl[8]  = '{1, 0, 0, 8, 0, 0, 1};
    tbl[9]  = '{1, 1, 0, 7, 0, 1, 1};
    tbl[10] = '{1, 0, 0, 8, 1, 0, 1};
    tbl[11] = '{0, 0, 0, 8, 0, 0, 1};
    tbl[12] = '{0, 1, 0, 7, 0, 1, 1};
    tbl[13] = '{0, 1, 0, 6, 0, 1, 1};
    tbl[14] = '{0, 1, 0, 5, 0, 1, 1};
    tbl[15] = '{1, 1, 1, 0, 0, 1, 0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_valid", 128'(dq_valid_o), 128'(0));
    chk("rst_full_n", 128'(issue_q_full_n), 128'(1));
    chk("rst_ack", 128'(ack_o), 128'(0));

    // A held request keeps its data until accepted.
    rand_data(cw, rv);
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].ld, cw, rv, tbl[i].rdy, tbl[i].fl, acc);
      chk($sformatf("tbl%0d_cnt", i), 128'(count_o), 128'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ack", i), 128'(ack_o), 128'(tbl[i].ack));
      chk($sformatf("tbl%0d_fn", i), 128'(issue_q_full_n), 128'(tbl[i].fn));
      chk($sformatf("tbl%0d_v", i), 128'(dq_valid_o), 128'(tbl[i].v));
      if (acc) rand_data(cw, rv);
    end

    // Stream 20 entries with random readiness across pointer wrap.
    sent = 0;
    budget = 0;
    rand_data(cw, rv);
    while ((sent < 20 || q.size() > 0) && budget < 500) begin
      cycle((sent < 20) && ($urandom_range(3) != 0), cw, rv,
            $urandom_range(1) == 1, 1'b0, acc);
      if (acc) begin
        sent++;
        rand_data(cw, rv);
      end
      budget++;
    end
    chk("stream_done", 128'(budget < 500), 128'(1));

    // Random traffic with occasional flush.
    for (int i = 0; i < 300; i++) begin
      rand_data(cw, rv);
      cycle($urandom_range(3) != 0, cw, rv, $urandom_range(2) == 0,
            $urandom_range(15) == 0, acc);
    end

    // Asynchronous reset with three entries and a pending ack.
    cycle(1'b0, cw, rv, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      rand_data(cw, rv);
      cycle(1'b1, cw, rv, 1'b0, 1'b0, acc);
    end
    chk("pre_rst_ack", 128'(ack_o), 128'(1));
    ld_iq = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(dq_valid_o), 128'(0));
    chk("arst_ack", 128'(ack_o), 128'(0));
    chk("arst_count", 128'(count_o), 128'(0));
    @(posedge clk);
    #2 ld_iq = 1'b0;
    rst = 1'b0;
    q.delete();
    ack_m = 0;
    @(negedge clk);
    chk("post_rst_count", 128'(count_o), 128'(0));
    chk("post_rst_ack", 128'(ack_o), 128'(0));
    chk("post_rst_full_n", 128'(issue_q_full_n), 128'(1));
    rand_data(cw, rv);
    cycle(1'b1, cw, rv, 1'b0, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
- In-order FIFO between the instruction register (producer) and dispatch/reservation-station allocation (consumer).
- Buffers decoded control words together with their RVFI records.
- Producer side: ld_iq request, issue_q_full_n back-pressure and one-cycle ack_o.
- Consumer side: valid/ready handshake; queue is cleared on pipeline flush.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
PTR_W, $clog2(DEPTH), index width; derived, not overridden

Ports:
clk  input  1  clock, all state rising-edge
rst  input  1  asynchronous active-high reset
flush  input  1  mispredict/exception flush; clears queue next edge
control_word  input  tomasula_types::ctl_word  decoded instruction from IR
ld_iq  input  1  IR requests enqueue of control_word/rvfi this cycle
rvfi  input  rv32i_types::rvfi_word  RVFI record paired with control_word
issue_q_full_n  output  1  high when at least one free entry
ack_o  output  1  one-cycle pulse: previous-cycle enqueue accepted
dq_valid_o  output  1  head entry valid
dq_ready_i  input  1  dispatch consumes head this cycle
dq_control_word  output  tomasula_types::ctl_word  head control word
dq_rvfi  output  rv32i_types::rvfi_word  head RVFI record
count_o  output  PTR_W+1  current occupancy, debug/perf

Behaviour:
- State: entry array DEPTH x {ctl_word, rvfi_word}; head_ptr and tail_ptr of PTR_W+1 bits (MSB is wrap bit); registered ack flop.
- Reset (async, rst=1): head_ptr=tail_ptr=0, ack_o=0. Hence issue_q_full_n=1, dq_valid_o=0, count_o=0. Entry contents are don't-care and are not reset.
- Occupancy: count_o = tail_ptr - head_ptr, computed modulo 2^(PTR_W+1).
- empty = (tail_ptr == head_ptr).
- full = index bits equal and wrap bits differ.
- issue_q_full_n = !full, combinational from registered pointers.
- dq_valid_o = !empty. dq_control_word/dq_rvfi = entry[head_ptr index], combinational read.
- Enqueue fires when ld_iq && issue_q_full_n && !flush:
  - write entry[tail index];
  - tail_ptr+1;
  - ack_o=1 on the next cycle only.
- ld_iq while full: ignored, no write, ack_o=0 next cycle. The IR must hold control_word/rvfi and retry.
- Dequeue fires when dq_valid_o && dq_ready_i && !flush: head_ptr+1.
- Simultaneous enqueue and dequeue:
  - both occur; count unchanged;
  - when full, issue_q_full_n is low, so no enqueue occurs (no same-cycle pass-through);
  - when empty, no dequeue occurs (no bypass); the new entry is visible at the head the next cycle.
- Latency: minimum enqueue-to-dq_valid_o is 1 cycle.
- Wrap-around: pointers increment modulo 2^(PTR_W+1). Index = low PTR_W bits.
- flush:
  - highest priority; next edge sets head_ptr=tail_ptr=0 and ack_o=0;
  - any same-cycle ld_iq is dropped and not acked;
  - same-cycle dq_ready_i is ignored.
- Reset mid-operation: immediate async clear to reset state; no ack is produced for an in-flight request.
- ack_o is never high for two cycles unless two consecutive enqueues were accepted.

Decomposition:
- tomasula_types package: ctl_word (existing); add IQ_DEPTH default constant and an iq_entry_t struct {ctl_word cw; rv32i_types::rvfi_word rvfi}.
- One sub-module: iq_storage, a DEPTH-entry array with one write port and one asynchronous read port, addressed by index.
- Pointer, count and handshake logic stay in instr_issue_queue.

Test Plan:
- Reset, then ld_iq=1 for one cycle with cw A:
  - ack_o=1 the next cycle;
  - dq_valid_o=1 with dq_control_word=A the next cycle;
  - count_o=1.
- Eight back-to-back enqueues with DEPTH=8 and dq_ready_i=0:
  - issue_q_full_n falls after the 8th;
  - a 9th ld_iq gives ack_o=0 and count_o stays 8.
- Full queue; assert dq_ready_i for one cycle with ld_iq held:
  - that cycle: head dequeued, no enqueue;
  - next cycle: issue_q_full_n=1 and the held request is accepted, giving ack_o=1 one cycle later.
- Stream 20 entries with random dq_ready_i, DEPTH=8:
  - output order equals input order across pointer wrap;
  - dq_rvfi is always paired with its own control word.
- Queue holding 5 entries; flush=1 with ld_iq=1 and dq_ready_i=1:
  - next cycle: count_o=0, dq_valid_o=0, issue_q_full_n=1, ack_o=0.
- Queue holding 3 entries; assert rst asynchronously mid-cycle:
  - outputs clear immediately: dq_valid_o=0, ack_o=0;
  - count_o=0 after release.
